// File: rtl/shift_register_ser.sv
// Parallel-to-serial shifter: SHIFT_NUM-bit words in over valid/ready, emitted LSB first.
// A one-word holding buffer keeps consecutive words contiguous on the serial line.
module shift_register_ser #(
  parameter int unsigned SHIFT_NUM = 4,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SHIFT_NUM-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_data,
  output logic                 o_frame,
  output logic                 o_busy
);

  localparam int unsigned     CntW    = $clog2(SHIFT_NUM + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SHIFT_NUM - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [SHIFT_NUM-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  // One spare MSB so the next bit is always sh_q[1], even for SHIFT_NUM=1.
  logic [SHIFT_NUM:0]   sh_q, sh_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 data_q, data_d;
  logic                 frame_q, frame_d;

  logic last, load, accept;

  always_comb begin
    last    = (state_q == StShift) && (bit_cnt_q == LastCnt);
    load    = hold_full_q && ((state_q == StIdle) || last);
    o_ready = !hold_full_q || load;
    accept  = i_valid && o_ready;
    o_busy  = (state_q == StShift) || hold_full_q;
    o_data  = data_q;
    o_frame = frame_q;
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    frame_d   = frame_q;
    if (load) begin
      sh_d      = {1'b0, hold_q};
      data_d    = hold_q[0];
      frame_d   = 1'b1;
      bit_cnt_d = '0;
      state_d   = StShift;
    end else if (last) begin
      state_d   = StIdle;
      data_d    = IDLE_BIT;
      frame_d   = 1'b0;
      bit_cnt_d = '0;
    end else if (state_q == StShift) begin
      data_d    = sh_q[1];
      sh_d      = sh_q >> 1;
      frame_d   = 1'b0;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      data_q      <= IDLE_BIT;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      frame_q     <= frame_d;
    end
  end

endmodule

// File: tb/tb_shift_register_ser.sv
// Bench for shift_register_ser: widths 4, 1 and 8; serial output regrouped on o_frame
// and scored against a queue of words pushed at acceptance.
module tb_shift_register_ser;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] d4 = '0; logic v4 = 1'b0; logic r4, od4, of4, b4;
  logic [0:0] d1 = '0; logic v1 = 1'b0; logic r1, od1, of1, b1;
  logic [7:0] d8 = '0; logic v8 = 1'b0; logic r8, od8, of8, b8;

  shift_register_ser #(.SHIFT_NUM(4), .IDLE_BIT(1'b0)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d4), .i_valid(v4),
    .o_ready(r4), .o_data(od4), .o_frame(of4), .o_busy(b4));
  shift_register_ser #(.SHIFT_NUM(1), .IDLE_BIT(1'b0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .i_valid(v1),
    .o_ready(r1), .o_data(od1), .o_frame(of1), .o_busy(b1));
  shift_register_ser #(.SHIFT_NUM(8), .IDLE_BIT(1'b1)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d8), .i_valid(v8),
    .o_ready(r8), .o_data(od8), .o_frame(of8), .o_busy(b8));

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp4[$], rx4[$];
  logic [0:0] exp1[$], rx1[$];
  logic [7:0] exp8[$], rx8[$];
  logic [1:0] log4[$];  // {o_frame, o_data} per cycle
  bit log_en = 1'b0;

  logic [3:0] acc4; logic [0:0] acc1; logic [7:0] acc8;
  int cnt4 = 0, cnt1 = 0, cnt8 = 0;

  // Regroup serial bits into words, starting a new word on every o_frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt4 = 0; cnt1 = 0; cnt8 = 0;
    end else begin
      if (of4) begin acc4 = '0; acc4[0] = od4; cnt4 = 1; end
      else if (cnt4 != 0) begin acc4[cnt4] = od4; cnt4++; end
      if (cnt4 == 4) begin rx4.push_back(acc4); cnt4 = 0; end
      if (of1) begin acc1 = '0; acc1[0] = od1; cnt1 = 1; end
      else if (cnt1 != 0) begin acc1[cnt1] = od1; cnt1++; end
      if (cnt1 == 1) begin rx1.push_back(acc1); cnt1 = 0; end
      if (of8) begin acc8 = '0; acc8[0] = od8; cnt8 = 1; end
      else if (cnt8 != 0) begin acc8[cnt8] = od8; cnt8++; end
      if (cnt8 == 8) begin rx8.push_back(acc8); cnt8 = 0; end
      if (log_en) log4.push_back({of4, od4});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one word to the 4-bit instance; scoreboard entry is pushed when it is accepted.
  task automatic drive_word4(input logic [3:0] w);
    int k;
    k = 0;
    d4 = w; v4 = 1'b1;
    while (!r4 && k < 100) begin tick(); k++; end
    if (!r4) begin
      n_cmp++; n_bad++;
      $display("FAIL drive_word4 timeout: o_ready=%b required 1", r4);
    end else begin
      exp4.push_back(w);
      tick();
    end
    v4 = 1'b0;
  endtask

  task automatic wait_words(input int which, input int n, output bit ok);
    int k;
    int sz;
    k = 0;
    ok = 1'b0;
    while (k < 400) begin
      case (which)
        1:       sz = rx1.size();
        8:       sz = rx8.size();
        default: sz = rx4.size();
      endcase
      if (sz >= n) begin ok = 1'b1; break; end
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({od4, of4, r4, b4} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_w4 data/frame/ready/busy=%b required 0010", {od4, of4, r4, b4});
    end
    n_cmp++;
    if ({od1, of1, r1, b1} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_w1 data/frame/ready/busy=%b required 0010", {od1, of1, r1, b1});
    end
    n_cmp++;
    if ({od8, of8, r8, b8} !== 4'b1010) begin
      n_bad++;
      $display("FAIL reset_w8 data/frame/ready/busy=%b required 1010", {od8, of8, r8, b8});
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [3:0] w;
    logic [3:0] r;
    bit ok;
    w = 4'b1011;
    drive_word4(w);  // now just after accepting edge E
    @(negedge clk);
    n_cmp++;
    if ({od4, of4, b4} !== 3'b001) begin
      n_bad++;
      $display("FAIL single_pre_load data/frame/busy=%b required 001", {od4, of4, b4});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({od4, of4, b4} !== {w[i], (i == 0), 1'b1}) begin
        n_bad++;
        $display("FAIL single_bit%0d data/frame/busy=%b required %b",
                 i, {od4, of4, b4}, {w[i], (i == 0), 1'b1});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({od4, of4, b4} !== 3'b000) begin
      n_bad++;
      $display("FAIL single_post data/frame/busy=%b required 000", {od4, of4, b4});
    end
    wait_words(4, 1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_rx timeout: got %0d words required 1", rx4.size());
    end else begin
      r = rx4.pop_front();
      w = exp4.pop_front();
      if (r !== w) begin
        n_bad++;
        $display("FAIL single_rx word=%h required %h", r, w);
      end
    end
    exp4.delete(); rx4.delete();
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits;
    logic [3:0] r, e;
    bit ok;
    int f;
    bits = 12'b1111_0101_1010;
    log4.delete(); log_en = 1'b1;
    drive_word4(4'hA); drive_word4(4'h5); drive_word4(4'hF);
    wait_words(4, 3, ok);
    tick(); log_en = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stream_rx timeout: got %0d words required 3", rx4.size());
    end
    while (exp4.size() != 0 && rx4.size() != 0) begin
      r = rx4.pop_front(); e = exp4.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL stream_word got=%h required %h", r, e); end
    end
    f = -1;
    for (int i = 0; i < log4.size(); i++) if (log4[i][1] === 1'b1) begin f = i; break; end
    n_cmp++;
    if (f < 0 || f + 12 > log4.size()) begin
      n_bad++;
      $display("FAIL stream_frame first frame index=%0d log=%0d required 12 bits", f, log4.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_cmp++;
        if (log4[f+i] !== {(i % 4 == 0), bits[i]}) begin
          n_bad++;
          $display("FAIL stream_bit%0d frame/data=%b required %b",
                   i, log4[f+i], {(i % 4 == 0), bits[i]});
        end
      end
    end
    exp4.delete(); rx4.delete(); log4.delete();
  endtask

  task automatic test_backpressure();
    logic [3:0] r, e;
    bit ok;
    int k;
    drive_word4(4'h1); drive_word4(4'h2);
    d4 = 4'h3; v4 = 1'b1;
    n_cmp++;
    if (r4 !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_ready_full o_ready=%b required 0", r4);
    end
    tick(); tick();
    d4 = 4'hC;
    k = 0;
    while (!r4 && k < 100) begin tick(); k++; end
    exp4.push_back(4'hC);
    tick(); v4 = 1'b0;
    wait_words(4, 3, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp_rx timeout: got %0d words required 3", rx4.size());
    end
    while (exp4.size() != 0) begin
      e = exp4.pop_front();
      r = (rx4.size() != 0) ? rx4.pop_front() : 4'hx;
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL bp_word got=%h required %h", r, e); end
    end
    tick(); tick();
    n_cmp++;
    if (rx4.size() != 0) begin
      n_bad++;
      $display("FAIL bp_extra words=%0d required 0", rx4.size());
    end
    exp4.delete(); rx4.delete();
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] r;
    bit ok;
    int f;
    drive_word4(4'h6);
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({od4, of4} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_bit1 data/frame=%b required 10", {od4, of4});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({od4, of4, r4, b4} !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_reset data/frame/ready/busy=%b required 0010", {od4, of4, r4, b4});
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    exp4.delete(); rx4.delete(); log4.delete();
    log_en = 1'b1;
    tick(); tick(); tick();
    drive_word4(4'h9);
    wait_words(4, 1, ok);
    tick(); log_en = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL mid_rx timeout: got %0d words required 1", rx4.size());
    end else begin
      r = rx4.pop_front();
      if (r !== 4'h9) begin n_bad++; $display("FAIL mid_rx word=%h required 9", r); end
    end
    f = -1;
    for (int i = 0; i < log4.size(); i++) if (log4[i][1] === 1'b1) begin f = i; break; end
    n_cmp++;
    if (f < 3 || f + 4 > log4.size()) begin
      n_bad++;
      $display("FAIL mid_frame first frame index=%0d required >=3 with 4 bits", f);
    end else begin
      for (int i = 0; i < f; i++) begin
        n_cmp++;
        if (log4[i] !== 2'b00) begin
          n_bad++;
          $display("FAIL mid_idle%0d frame/data=%b required 00", i, log4[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log4[f+i] !== {(i == 0), (i == 0 || i == 3)}) begin
          n_bad++;
          $display("FAIL mid_bit%0d frame/data=%b required %b",
                   i, log4[f+i], {(i == 0), (i == 0 || i == 3)});
        end
      end
    end
    exp4.delete(); rx4.delete(); log4.delete();
  endtask

  task automatic test_random_w1();
    logic [0:0] r, e;
    bit ok;
    for (int c = 0; c < 120; c++) begin
      v1 = ($urandom_range(0, 3) != 0);
      d1 = 1'($urandom);
      if (v1 && r1) exp1.push_back(d1);
      tick();
    end
    v1 = 1'b0;
    wait_words(1, exp1.size(), ok);
    tick(); tick();
    n_cmp++;
    if (!ok || rx1.size() != exp1.size()) begin
      n_bad++;
      $display("FAIL rand_w1_count got=%0d required %0d", rx1.size(), exp1.size());
    end
    while (exp1.size() != 0 && rx1.size() != 0) begin
      r = rx1.pop_front(); e = exp1.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL rand_w1_word got=%h required %h", r, e); end
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] r, e;
    bit ok;
    for (int c = 0; c < 300; c++) begin
      v8 = ($urandom_range(0, 2) != 0);
      d8 = 8'($urandom);
      if (v8 && r8) exp8.push_back(d8);
      tick();
    end
    v8 = 1'b0;
    wait_words(8, exp8.size(), ok);
    tick(); tick();
    n_cmp++;
    if (!ok || rx8.size() != exp8.size()) begin
      n_bad++;
      $display("FAIL rand_w8_count got=%0d required %0d", rx8.size(), exp8.size());
    end
    while (exp8.size() != 0 && rx8.size() != 0) begin
      r = rx8.pop_front(); e = exp8.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL rand_w8_word got=%h required %h", r, e); end
    end
    n_cmp++;
    if ({od8, of8, b8} !== 3'b100) begin
      n_bad++;
      $display("FAIL rand_w8_idle data/frame/busy=%b required 100", {od8, of8, b8});
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random_w1();
    test_random_w8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
